// File: rtl/demux1to4_tdm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux1to4_tdm_pkg
// Brief    : Shared constants and types for the 4-channel TDM demultiplexer.
// Revision : 1.0  initial release
// ============================================================================
package demux1to4_tdm_pkg;

    localparam int SLOT_W = 2;
    localparam int NCH    = 4;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    function automatic logic [NCH-1:0] slot_onehot(input logic [SLOT_W-1:0] s);
        logic [NCH-1:0] oh;
        oh    = '0;
        oh[s] = 1'b1;
        return oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux1to4_tdm_slot_counter.sv
`default_nettype none
// ============================================================================
// Module   : demux_slot_counter
// Brief    : Mod-4 slot counter with clear, realign (load-to-1) and enable.
// Revision : 1.0  initial release
// ============================================================================
module demux_slot_counter
    import demux1to4_tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_load1,
    input  logic              i_en,
    output logic [SLOT_W-1:0] o_slot
);

    logic [SLOT_W-1:0] r_slot;

    // Clear wins over realign, realign wins over a plain advance.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_slot <= '0;
        end else if (i_load1) begin
            r_slot <= SLOT_W'(1);
        end else if (i_en) begin
            r_slot <= r_slot + SLOT_W'(1);
        end
    end

    assign o_slot = r_slot;

endmodule
`default_nettype wire

// File: rtl/demux1to4_tdm.sv
`default_nettype none
// ============================================================================
// Module   : demux1to4_tdm
// Brief    : TDM receive demux: routes samples to 4 channel registers and
//            tracks frame alignment with a HUNT/LOCKED flywheel.
// Revision : 1.0  initial release
// ============================================================================
module demux1to4_tdm
    import demux1to4_tdm_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int SYNC_LOSS_LIMIT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     din,
    input  logic                 fsync,
    output logic [4*WIDTH-1:0]   y,
    output logic [3:0]           ch_valid,
    output logic                 frame_done,
    output logic                 locked,
    output logic                 sync_err,
    output logic [1:0]           slot
);

    state_t            r_state;
    logic [2:0]        r_miss_cnt;
    logic [NCH-1:0]    r_ch_valid;
    logic              r_frame_done;
    logic              r_sync_err;
    logic [WIDTH-1:0]  r_y [NCH];

    logic [SLOT_W-1:0] w_slot;
    logic              w_write;
    logic [SLOT_W-1:0] w_wr_idx;
    logic              w_frame_done;
    logic              w_set_err;
    logic              w_cnt_clr;
    logic              w_cnt_load1;
    logic              w_cnt_en;
    state_t            w_next_state;
    logic [2:0]        w_miss_next;
    logic              w_flywheel_ok;

    demux_slot_counter u_slot_counter (
        .clk     (clk),
        .rst     (reset),
        .i_clr   (w_cnt_clr),
        .i_load1 (w_cnt_load1),
        .i_en    (w_cnt_en),
        .o_slot  (w_slot)
    );

    // One more missed sync is tolerated while the miss count stays under the limit.
    assign w_flywheel_ok = ({1'b0, r_miss_cnt} + 4'd1) < 4'(SYNC_LOSS_LIMIT);

    always_comb begin
        w_write      = 1'b0;
        w_wr_idx     = w_slot;
        w_frame_done = 1'b0;
        w_set_err    = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_load1  = 1'b0;
        w_cnt_en     = 1'b0;
        w_next_state = r_state;
        w_miss_next  = r_miss_cnt;
        if (in_valid) begin
            if (r_state == ST_HUNT) begin
                if (fsync) begin
                    w_write      = 1'b1;
                    w_wr_idx     = '0;
                    w_cnt_load1  = 1'b1;
                    w_miss_next  = '0;
                    w_next_state = ST_LOCKED;
                end
            end else if (fsync) begin
                // Good frame start, or early sync realigned onto slot 0.
                w_write     = 1'b1;
                w_wr_idx    = '0;
                w_cnt_load1 = 1'b1;
                w_miss_next = '0;
                w_set_err   = (w_slot != '0);
            end else if (w_slot != '0) begin
                w_write      = 1'b1;
                w_cnt_en     = 1'b1;
                w_frame_done = (w_slot == SLOT_W'(NCH-1));
            end else if (w_flywheel_ok) begin
                w_write     = 1'b1;
                w_wr_idx    = '0;
                w_cnt_load1 = 1'b1;
                w_miss_next = r_miss_cnt + 3'd1;
            end else begin
                w_set_err    = 1'b1;
                w_cnt_clr    = 1'b1;
                w_miss_next  = '0;
                w_next_state = ST_HUNT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_HUNT;
            r_miss_cnt   <= '0;
            r_ch_valid   <= '0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_miss_cnt   <= w_miss_next;
            r_ch_valid   <= w_write ? slot_onehot(w_wr_idx) : '0;
            r_frame_done <= w_frame_done;
            if (w_set_err) begin
                r_sync_err <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        always_ff @(posedge clk) begin
            if (reset) begin
                r_y[i] <= '0;
            end else if (w_write && (w_wr_idx == SLOT_W'(i))) begin
                r_y[i] <= din;
            end
        end
        assign y[i*WIDTH +: WIDTH] = r_y[i];
    end

    assign ch_valid   = r_ch_valid;
    assign frame_done = r_frame_done;
    assign locked     = (r_state == ST_LOCKED);
    assign sync_err   = r_sync_err;
    assign slot       = w_slot;

endmodule
`default_nettype wire

// File: tb/tb_demux1to4_tdm.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux1to4_tdm
// Brief    : Scoreboard testbench for demux1to4_tdm (WIDTH=4, SYNC_LOSS_LIMIT=2).
// Revision : 1.0  initial release
// ============================================================================
module tb_demux1to4_tdm;

    localparam int WIDTH = 4;
    localparam int LIMIT = 2;

    logic             clk      = 1'b0;
    logic             reset    = 1'b1;
    logic             in_valid = 1'b0;
    logic             fsync    = 1'b0;
    logic [WIDTH-1:0] din      = '0;
    logic [15:0]      y;
    logic [3:0]       ch_valid;
    logic             frame_done;
    logic             locked;
    logic             sync_err;
    logic [1:0]       slot;

    demux1to4_tdm #(.WIDTH(WIDTH), .SYNC_LOSS_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .din        (din),
        .fsync      (fsync),
        .y          (y),
        .ch_valid   (ch_valid),
        .frame_done (frame_done),
        .locked     (locked),
        .sync_err   (sync_err),
        .slot       (slot)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] y;
        logic [3:0]  chv;
        logic        fd;
        logic        lk;
        logic        se;
        logic [1:0]  sl;
    } obs_t;

    obs_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model state
    logic [3:0] m_y [4];
    logic [1:0] m_sl;
    int         m_miss;
    logic       m_lk;
    logic       m_se;

    function automatic obs_t dut_obs();
        return {y, ch_valid, frame_done, locked, sync_err, slot};
    endfunction

    // Drive one cycle, predict the outcome, queue it, advance past the edge.
    task automatic cyc(input logic r, input logic v, input logic f, input logic [3:0] d);
        obs_t e;
        reset = r; in_valid = v; fsync = f; din = d;
        e.chv = 4'b0000;
        e.fd  = 1'b0;
        if (r) begin
            m_y = '{default: 4'h0}; m_sl = 2'd0; m_miss = 0; m_lk = 1'b0; m_se = 1'b0;
        end else if (v) begin
            if (!m_lk) begin
                if (f) begin
                    m_y[0] = d; e.chv = 4'b0001; m_sl = 2'd1; m_miss = 0; m_lk = 1'b1;
                end
            end else if (f) begin
                if (m_sl != 2'd0) m_se = 1'b1;
                m_y[0] = d; e.chv = 4'b0001; m_sl = 2'd1; m_miss = 0;
            end else if (m_sl != 2'd0) begin
                m_y[m_sl] = d; e.chv = 4'b0001 << m_sl; e.fd = (m_sl == 2'd3);
                m_sl = m_sl + 2'd1;
            end else if (m_miss + 1 < LIMIT) begin
                m_y[0] = d; e.chv = 4'b0001; m_sl = 2'd1; m_miss++;
            end else begin
                m_se = 1'b1; m_lk = 1'b0; m_sl = 2'd0; m_miss = 0;
            end
        end
        e.y  = {m_y[3], m_y[2], m_y[1], m_y[0]};
        e.lk = m_lk;
        e.se = m_se;
        e.sl = m_sl;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t e, a;
        cyc(1'b1, 1'b1, 1'b1, 4'hF);
        e = sb.pop_front(); a = dut_obs(); n_cmp++;
        if (a !== e) begin
            n_fail++; $display("FAIL reset_sb: got %h expected %h", a, e);
        end
        n_cmp++;
        if (a !== '0) begin
            n_fail++; $display("FAIL reset_zero: got %h expected 0", a);
        end
    endtask

    task automatic test_lock_frame();
        logic [6:0] st [6] = '{7'b1_0_0_0000, 7'b0_1_1_1010, 7'b0_1_0_1011,
                               7'b0_1_0_1100, 7'b0_1_0_1101, 7'b0_0_0_0000};
        obs_t e, a;
        int   n_fd = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(st[i][6], st[i][5], st[i][4], st[i][3:0]);
            e = sb.pop_front(); a = dut_obs(); n_cmp++;
            if (a !== e) begin
                n_fail++; $display("FAIL lock_frame step%0d: got %h expected %h", i, a, e);
            end
            n_fd += int'(frame_done);
        end
        n_cmp++;
        if (y !== 16'hDCBA || locked !== 1'b1 || sync_err !== 1'b0 || n_fd != 1) begin
            n_fail++;
            $display("FAIL lock_frame_final: got y=%h locked=%b sync_err=%b fd_pulses=%0d expected y=dcba locked=1 sync_err=0 fd_pulses=1",
                     y, locked, sync_err, n_fd);
        end
    endtask

    task automatic test_hunt_discard();
        logic [6:0] st [4] = '{7'b1_0_0_0000, 7'b0_1_0_0101, 7'b0_1_0_0110, 7'b0_1_1_0111};
        obs_t e, a;
        logic bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(st[i][6], st[i][5], st[i][4], st[i][3:0]);
            e = sb.pop_front(); a = dut_obs(); n_cmp++;
            if (a !== e) begin
                n_fail++; $display("FAIL hunt_discard step%0d: got %h expected %h", i, a, e);
            end
            if (i < 3 && (locked !== 1'b0 || y !== 16'h0000 || ch_valid !== 4'b0000)) bad = 1'b1;
        end
        n_cmp++;
        if (bad !== 1'b0 || y !== 16'h0007 || ch_valid !== 4'b0001 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL hunt_discard_final: got early_activity=%b y=%h ch_valid=%b locked=%b expected 0 0007 0001 1",
                     bad, y, ch_valid, locked);
        end
    endtask

    task automatic test_gaps();
        logic [6:0] st [9] = '{7'b1_0_0_0000, 7'b0_1_1_0001, 7'b0_1_0_0010, 7'b0_0_0_0000,
                               7'b0_0_0_0000, 7'b0_0_0_0000, 7'b0_1_0_0011, 7'b0_1_0_0100,
                               7'b0_0_0_0000};
        obs_t e, a;
        logic bad = 1'b0;
        int   n_fd = 0;
        for (int i = 0; i < 9; i++) begin
            cyc(st[i][6], st[i][5], st[i][4], st[i][3:0]);
            e = sb.pop_front(); a = dut_obs(); n_cmp++;
            if (a !== e) begin
                n_fail++; $display("FAIL gaps step%0d: got %h expected %h", i, a, e);
            end
            if (i >= 3 && i <= 5 && (slot !== 2'd2 || ch_valid !== 4'b0000 || frame_done !== 1'b0)) bad = 1'b1;
            n_fd += int'(frame_done);
        end
        n_cmp++;
        if (bad !== 1'b0 || y !== 16'h4321 || n_fd != 1) begin
            n_fail++;
            $display("FAIL gaps_final: got gap_activity=%b y=%h fd_pulses=%0d expected 0 4321 1", bad, y, n_fd);
        end
    endtask

    task automatic test_early_sync();
        logic [6:0] st [4] = '{7'b1_0_0_0000, 7'b0_1_1_0001, 7'b0_1_0_0010, 7'b0_1_1_1001};
        obs_t e, a;
        for (int i = 0; i < 4; i++) begin
            cyc(st[i][6], st[i][5], st[i][4], st[i][3:0]);
            e = sb.pop_front(); a = dut_obs(); n_cmp++;
            if (a !== e) begin
                n_fail++; $display("FAIL early_sync step%0d: got %h expected %h", i, a, e);
            end
        end
        n_cmp++;
        if (sync_err !== 1'b1 || y[3:0] !== 4'h9 || slot !== 2'd1 || locked !== 1'b1 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL early_sync_final: got sync_err=%b ch0=%h slot=%0d locked=%b fd=%b expected 1 9 1 1 0",
                     sync_err, y[3:0], slot, locked, frame_done);
        end
    endtask

    task automatic test_sync_loss();
        logic [6:0] st [13] = '{7'b1_0_0_0000, 7'b0_1_1_0001, 7'b0_1_0_0010, 7'b0_1_0_0011,
                                7'b0_1_0_0100, 7'b0_1_0_0101, 7'b0_1_0_0110, 7'b0_1_0_0111,
                                7'b0_1_0_1000, 7'b0_1_0_1001, 7'b0_1_0_1010, 7'b0_1_0_1011,
                                7'b0_1_0_1100};
        obs_t e, a;
        logic fly_ok = 1'b0;
        logic lost_ok = 1'b0;
        for (int i = 0; i < 13; i++) begin
            cyc(st[i][6], st[i][5], st[i][4], st[i][3:0]);
            e = sb.pop_front(); a = dut_obs(); n_cmp++;
            if (a !== e) begin
                n_fail++; $display("FAIL sync_loss step%0d: got %h expected %h", i, a, e);
            end
            if (i == 5) fly_ok = (locked === 1'b1 && y[3:0] === 4'h5 && sync_err === 1'b0);
            if (i == 9) lost_ok = (locked === 1'b0 && sync_err === 1'b1 && slot === 2'd0 &&
                                   ch_valid === 4'b0000 && y[3:0] === 4'h5);
        end
        n_cmp++;
        if (fly_ok !== 1'b1 || lost_ok !== 1'b1 || locked !== 1'b0 || y !== 16'h8765) begin
            n_fail++;
            $display("FAIL sync_loss_final: got flywheel_ok=%b loss_ok=%b locked=%b y=%h expected 1 1 0 8765",
                     fly_ok, lost_ok, locked, y);
        end
    endtask

    task automatic test_reset_midframe();
        logic [6:0] st [9] = '{7'b1_0_0_0000, 7'b0_1_1_0001, 7'b0_1_0_0010, 7'b1_1_1_1110,
                               7'b0_1_1_1010, 7'b0_1_0_1011, 7'b0_1_0_1100, 7'b0_1_0_1101,
                               7'b0_0_0_0000};
        obs_t e, a;
        obs_t at_reset = '1;
        for (int i = 0; i < 9; i++) begin
            cyc(st[i][6], st[i][5], st[i][4], st[i][3:0]);
            e = sb.pop_front(); a = dut_obs(); n_cmp++;
            if (a !== e) begin
                n_fail++; $display("FAIL reset_midframe step%0d: got %h expected %h", i, a, e);
            end
            if (i == 3) at_reset = a;
        end
        n_cmp++;
        if (at_reset !== '0 || y !== 16'hDCBA || locked !== 1'b1 || sync_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midframe_final: got at_reset=%h y=%h locked=%b sync_err=%b expected 0 dcba 1 0",
                     at_reset, y, locked, sync_err);
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, a;
        cyc(1'b1, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 300; i++) begin
            e = sb.pop_front(); a = dut_obs(); n_cmp++;
            if (a !== e) begin
                n_fail++; $display("FAIL back_to_back step%0d: got %h expected %h", i, a, e);
            end
            cyc(($urandom % 97) == 0, ($urandom % 5) != 0, ($urandom % 6) == 0, 4'($urandom));
        end
        e = sb.pop_front(); a = dut_obs(); n_cmp++;
        if (a !== e) begin
            n_fail++; $display("FAIL back_to_back last: got %h expected %h", a, e);
        end
    endtask

    initial begin
        m_y = '{default: 4'h0}; m_sl = 2'd0; m_miss = 0; m_lk = 1'b0; m_se = 1'b0;
        test_reset();
        test_lock_frame();
        test_hunt_discard();
        test_gaps();
        test_early_sync();
        test_sync_loss();
        test_reset_midframe();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/demux1to4_tdm.md
Name: demux1to4_tdm

Overview:
Receive end of a 4-channel time-division link whose transmit end is a 4-to-1 mux stepped by a slot counter. The block takes one multiplexed sample stream plus a frame-sync marker. It routes each sample to one of four registered channel outputs and tracks frame alignment with a HUNT/LOCKED state machine. It reports misalignment and loss of sync.

Parameters:
WIDTH, 4, bit width of one channel sample
SYNC_LOSS_LIMIT, 2, consecutive slot-0 samples arriving without fsync that force a return to HUNT (range 1..7)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  din/fsync carry a sample this cycle
din  input  WIDTH  multiplexed sample
fsync  input  1  marks the slot-0 sample of a frame; ignored when in_valid=0
y  output  4*WIDTH  channel registers; channel i at y[i*WIDTH +: WIDTH]
ch_valid  output  4  one-cycle pulse, bit i set the cycle channel i is updated
frame_done  output  1  one-cycle pulse when slot 3 is written while LOCKED
locked  output  1  high in LOCKED state
sync_err  output  1  sticky misalignment flag, cleared only by reset
slot  output  2  slot index expected for the next sample

Behaviour:
- Reset (synchronous, active-high; dominates all other inputs): y=0, ch_valid=0, frame_done=0, locked=0, sync_err=0, slot=0, miss_cnt=0, state=HUNT.
- All outputs are registered. A sample accepted at edge N is visible on y at edge N, and ch_valid/frame_done pulse in the following cycle. Latency is 1 clock.
- in_valid=0: hold y, slot, state and miss_cnt; ch_valid=0; frame_done=0.
- HUNT, in_valid=1, fsync=0: sample discarded; no pulse.
- HUNT, in_valid=1, fsync=1: write din to ch0; ch_valid=0001; slot<=1; miss_cnt<=0; go LOCKED (locked=1 on the same edge).
- LOCKED, slot=s≠0, fsync=0: write din to ch s; ch_valid bit s; slot<=s+1 mod 4. When s=3, also pulse frame_done and set slot<=0.
- LOCKED, slot=0, fsync=1 (good frame start): write ch0; slot<=1; miss_cnt<=0.
- LOCKED, slot≠0, fsync=1 (early sync): sync_err<=1. Realign by treating the sample as slot 0: write ch0, slot<=1, miss_cnt<=0. No frame_done for the truncated frame.
- LOCKED, slot=0, fsync=0 (missing sync), flywheel rule:
  - If miss_cnt+1 < SYNC_LOSS_LIMIT: write ch0, slot<=1, miss_cnt<=miss_cnt+1.
  - Otherwise: discard the sample, sync_err<=1, go HUNT, locked<=0, slot<=0, miss_cnt<=0.
- y channels not addressed in a cycle hold their value. Exactly one ch_valid bit is set per accepted sample.
- Reset asserted mid-frame clears all state; the partial frame is lost.
- miss_cnt is 3 bits and saturates by construction (cleared before overflow).

Decomposition:
- Shared package holds:
  - State encoding constants ST_HUNT=1'b0, ST_LOCKED=1'b1.
  - Slot width constant SLOT_W=2.
  - Channel count NCH=4.
- One natural sub-module, demux_slot_counter: a 2-bit mod-4 counter with synchronous clear, load-to-1 (realign) and enable. Its output drives slot and the decode that selects the channel register.
- The channel register bank and the state machine stay in the top module.

Test Plan:
- Settings: WIDTH=4, SYNC_LOSS_LIMIT=2 throughout.
- Lock and frame: after reset, send A,B,C,D with fsync on A, in_valid=1 each cycle -> y=0xDCBA, ch_valid 0001,0010,0100,1000 on consecutive cycles, frame_done one pulse after D, locked=1, sync_err=0.
- Hunt discard: after reset, send 5,6 with fsync=0, then 7 with fsync=1 -> locked stays 0 and y=0 for 5,6; y[3:0]=7 with ch_valid=0001 after 7.
- Gaps: frame 1,2,3,4 with in_valid=0 for 3 cycles between samples 2 and 3 -> no pulses during gaps, slot holds 2, final y=0x4321, frame_done once.
- Early sync: locked; send 1,2 then 9 with fsync=1 -> sync_err=1, y[3:0]=9, slot=1, locked stays 1, no frame_done.
- Sync loss: locked; two full frames with fsync=0 at slot 0 -> first frame flywheels (ch0 written, locked=1); next slot-0 sample discarded, locked=0, sync_err=1, slot=0.
- Reset mid-frame: locked after 2 samples, assert reset 1 cycle -> all outputs 0, HUNT; a following fsync frame locks normally.
